gmem_axi_slave_mem: RTL and testbench

AXI4 memory-mapped slave that answers the kernel-side `m_axi_gmem` master: it accepts INCR read and write bursts and serves them from an on-chip word array. It sits at the far end of the kernel's global-memory port. Its uses are simulation benches and standalone hardware bring-up, where it replaces the platform DDR path. One read and one write transaction may be outstanding at a time, and the two paths run independently.

---
 rtl/gmem_axi_pkg.sv | 23 ++
 rtl/gmem_axi_ram_array.sv | 39 +++
 rtl/gmem_axi_slave_mem.sv | 189 ++++++++++++++++++
 tb/tb_gmem_axi_slave_mem.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmem_axi_pkg.sv
// Shared constants and state types for the gmem AXI4 slave memory model.
package gmem_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Number of byte-offset address bits below the word index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/gmem_axi_ram_array.sv
// Word array with one byte-enabled write port and one registered read port.
module gmem_axi_ram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    wr_en,
    input  logic [DEPTH_LOG2-1:0]   wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic                    rd_zero,
    input  logic [DEPTH_LOG2-1:0]   rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge ap_clk) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (wr_en && wr_strb[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read samples the array before this edge's write lands: old data on collision.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/gmem_axi_slave_mem.sv
// AXI4 INCR-burst slave memory for the kernel m_axi_gmem port.
// Define GMEM_SLAVE_RANGE_CHECK_EN to flag and suppress beats above the array range.
//
// state  | meaning
// W_IDLE | waiting for AW
// W_DATA | accepting write beats
// W_RESP | presenting B response
// R_IDLE | waiting for AR
// R_DATA | presenting read beats
module gmem_axi_slave_mem
    import gmem_axi_pkg::*;
#(
    parameter int C_S_AXI_GMEM_ADDR_WIDTH = 64,
    parameter int C_S_AXI_GMEM_DATA_WIDTH = 32,
    parameter int C_S_AXI_GMEM_ID_WIDTH   = 1,
    parameter int C_MEM_DEPTH_LOG2        = 10
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst_n,
    input  logic                                 s_axi_gmem_AWVALID,
    output logic                                 s_axi_gmem_AWREADY,
    input  logic [C_S_AXI_GMEM_ADDR_WIDTH-1:0]   s_axi_gmem_AWADDR,
    input  logic [C_S_AXI_GMEM_ID_WIDTH-1:0]     s_axi_gmem_AWID,
    input  logic [7:0]                           s_axi_gmem_AWLEN,
    input  logic                                 s_axi_gmem_WVALID,
    output logic                                 s_axi_gmem_WREADY,
    input  logic [C_S_AXI_GMEM_DATA_WIDTH-1:0]   s_axi_gmem_WDATA,
    input  logic [C_S_AXI_GMEM_DATA_WIDTH/8-1:0] s_axi_gmem_WSTRB,
    input  logic                                 s_axi_gmem_WLAST,
    output logic                                 s_axi_gmem_BVALID,
    input  logic                                 s_axi_gmem_BREADY,
    output logic [1:0]                           s_axi_gmem_BRESP,
    output logic [C_S_AXI_GMEM_ID_WIDTH-1:0]     s_axi_gmem_BID,
    input  logic                                 s_axi_gmem_ARVALID,
    output logic                                 s_axi_gmem_ARREADY,
    input  logic [C_S_AXI_GMEM_ADDR_WIDTH-1:0]   s_axi_gmem_ARADDR,
    input  logic [C_S_AXI_GMEM_ID_WIDTH-1:0]     s_axi_gmem_ARID,
    input  logic [7:0]                           s_axi_gmem_ARLEN,
    output logic                                 s_axi_gmem_RVALID,
    input  logic                                 s_axi_gmem_RREADY,
    output logic [C_S_AXI_GMEM_DATA_WIDTH-1:0]   s_axi_gmem_RDATA,
    output logic                                 s_axi_gmem_RLAST,
    output logic [C_S_AXI_GMEM_ID_WIDTH-1:0]     s_axi_gmem_RID,
    output logic [1:0]                           s_axi_gmem_RRESP
);

    localparam int ADDR_LSB = addr_lsb(C_S_AXI_GMEM_DATA_WIDTH);
    localparam int WA_W     = C_S_AXI_GMEM_ADDR_WIDTH - ADDR_LSB;

    wr_state_t w_state, w_state_nxt;
    rd_state_t r_state, r_state_nxt;
    logic      run_q;

    // Word addresses keep the upper bits so the range check can see carries.
    logic [WA_W-1:0] w_addr_q;
    logic [WA_W-1:0] r_addr_q;
    logic [WA_W-1:0] r_rd_addr;
    logic [7:0]      w_cnt_q;
    logic [7:0]      r_cnt_q;
    logic            w_err_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_oor, r_oor;
    logic ram_we, ram_re;

    assign aw_hs = s_axi_gmem_AWVALID && s_axi_gmem_AWREADY;
    assign w_hs  = s_axi_gmem_WVALID  && s_axi_gmem_WREADY;
    assign b_hs  = s_axi_gmem_BVALID  && s_axi_gmem_BREADY;
    assign ar_hs = s_axi_gmem_ARVALID && s_axi_gmem_ARREADY;
    assign r_hs  = s_axi_gmem_RVALID  && s_axi_gmem_RREADY;

`ifdef GMEM_SLAVE_RANGE_CHECK_EN
    assign w_oor = |w_addr_q[WA_W-1:C_MEM_DEPTH_LOG2];
    assign r_oor = |r_rd_addr[WA_W-1:C_MEM_DEPTH_LOG2];
`else
    logic unused_hi;
    assign w_oor     = 1'b0;
    assign r_oor     = 1'b0;
    assign unused_hi = ^{w_addr_q[WA_W-1:C_MEM_DEPTH_LOG2], r_rd_addr[WA_W-1:C_MEM_DEPTH_LOG2]};
`endif

    logic unused_in;
    assign unused_in = ^{s_axi_gmem_AWADDR[ADDR_LSB-1:0], s_axi_gmem_ARADDR[ADDR_LSB-1:0],
                         s_axi_gmem_WLAST};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            run_q   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && (w_cnt_q == 8'd0)) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase

        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && (r_cnt_q == 8'd0)) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // run_q keeps the address channels closed until the first edge after reset.
    always_comb begin
        s_axi_gmem_AWREADY = run_q && (w_state == W_IDLE);
        s_axi_gmem_WREADY  = (w_state == W_DATA);
        s_axi_gmem_BVALID  = (w_state == W_RESP);
        s_axi_gmem_ARREADY = run_q && (r_state == R_IDLE);
        s_axi_gmem_RVALID  = (r_state == R_DATA);
        ram_we             = w_hs && !w_oor;
        ram_re             = ar_hs || (r_hs && (r_cnt_q != 8'd0));
        r_rd_addr          = (r_state == R_IDLE) ? s_axi_gmem_ARADDR[C_S_AXI_GMEM_ADDR_WIDTH-1:ADDR_LSB]
                                                 : r_addr_q + WA_W'(1);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_addr_q         <= '0;
            w_cnt_q          <= 8'd0;
            w_err_q          <= 1'b0;
            s_axi_gmem_BID   <= '0;
            s_axi_gmem_BRESP <= RESP_OKAY;
        end else if (aw_hs) begin
            w_addr_q       <= s_axi_gmem_AWADDR[C_S_AXI_GMEM_ADDR_WIDTH-1:ADDR_LSB];
            w_cnt_q        <= s_axi_gmem_AWLEN;
            w_err_q        <= 1'b0;
            s_axi_gmem_BID <= s_axi_gmem_AWID;
        end else if (w_hs) begin
            w_addr_q <= w_addr_q + WA_W'(1);
            w_cnt_q  <= w_cnt_q - 8'd1;
            w_err_q  <= w_err_q | w_oor;
            if (w_cnt_q == 8'd0) begin
                s_axi_gmem_BRESP <= (w_err_q || w_oor) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_addr_q         <= '0;
            r_cnt_q          <= 8'd0;
            s_axi_gmem_RID   <= '0;
            s_axi_gmem_RLAST <= 1'b0;
            s_axi_gmem_RRESP <= RESP_OKAY;
        end else begin
            if (ram_re) begin
                r_addr_q         <= r_rd_addr;
                s_axi_gmem_RRESP <= r_oor ? RESP_SLVERR : RESP_OKAY;
            end
            if (ar_hs) begin
                r_cnt_q          <= s_axi_gmem_ARLEN;
                s_axi_gmem_RID   <= s_axi_gmem_ARID;
                s_axi_gmem_RLAST <= (s_axi_gmem_ARLEN == 8'd0);
            end else if (r_hs && (r_cnt_q != 8'd0)) begin
                r_cnt_q          <= r_cnt_q - 8'd1;
                s_axi_gmem_RLAST <= (r_cnt_q == 8'd1);
            end
        end
    end

    gmem_axi_ram_array #(
        .DATA_WIDTH (C_S_AXI_GMEM_DATA_WIDTH),
        .DEPTH_LOG2 (C_MEM_DEPTH_LOG2)
    ) u_ram (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .wr_en    (ram_we),
        .wr_idx   (w_addr_q[C_MEM_DEPTH_LOG2-1:0]),
        .wr_data  (s_axi_gmem_WDATA),
        .wr_strb  (s_axi_gmem_WSTRB),
        .rd_en    (ram_re),
        .rd_zero  (r_oor),
        .rd_idx   (r_rd_addr[C_MEM_DEPTH_LOG2-1:0]),
        .rd_data  (s_axi_gmem_RDATA)
    );

endmodule

// File: tb/tb_gmem_axi_slave_mem.sv
// Scoreboard bench for gmem_axi_slave_mem against a word-array reference model.
module tb_gmem_axi_slave_mem;

    localparam int DEPTH = 1024;
    localparam int TMO   = 400;
`ifdef GMEM_SLAVE_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic        ap_clk, ap_rst_n;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [63:0] awaddr, araddr;
    logic        awid, bid, arid, rid;
    logic [7:0]  awlen, arlen;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready, rlast;

    gmem_axi_slave_mem dut (
        .ap_clk             (ap_clk),
        .ap_rst_n           (ap_rst_n),
        .s_axi_gmem_AWVALID (awvalid),
        .s_axi_gmem_AWREADY (awready),
        .s_axi_gmem_AWADDR  (awaddr),
        .s_axi_gmem_AWID    (awid),
        .s_axi_gmem_AWLEN   (awlen),
        .s_axi_gmem_WVALID  (wvalid),
        .s_axi_gmem_WREADY  (wready),
        .s_axi_gmem_WDATA   (wdata),
        .s_axi_gmem_WSTRB   (wstrb),
        .s_axi_gmem_WLAST   (wlast),
        .s_axi_gmem_BVALID  (bvalid),
        .s_axi_gmem_BREADY  (bready),
        .s_axi_gmem_BRESP   (bresp),
        .s_axi_gmem_BID     (bid),
        .s_axi_gmem_ARVALID (arvalid),
        .s_axi_gmem_ARREADY (arready),
        .s_axi_gmem_ARADDR  (araddr),
        .s_axi_gmem_ARID    (arid),
        .s_axi_gmem_ARLEN   (arlen),
        .s_axi_gmem_RVALID  (rvalid),
        .s_axi_gmem_RREADY  (rready),
        .s_axi_gmem_RDATA   (rdata),
        .s_axi_gmem_RLAST   (rlast),
        .s_axi_gmem_RID     (rid),
        .s_axi_gmem_RRESP   (rresp)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct { logic [31:0] data; logic last; logic id; logic [1:0] resp; } r_exp_t;
    typedef struct { logic id; logic [1:0] resp; } b_exp_t;
    r_exp_t exp_r[$];
    b_exp_t exp_b[$];

    logic [31:0] mdl [DEPTH];
    logic [31:0] wq_d[$];
    logic [3:0]  wq_s[$];

    int rr_mode = 0;
    bit br_rand = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [63:0] beat_word(input logic [63:0] a, input int i);
        return (a >> 2) + 64'(i);
    endfunction

    function automatic bit beat_oor(input logic [63:0] w);
        return RANGE && (w >= 64'(DEPTH));
    endfunction

    function automatic int widx(input logic [63:0] w);
        return int'(w % 64'(DEPTH));
    endfunction

    task automatic model_write(input logic [63:0] w, input logic [31:0] d, input logic [3:0] s);
        if (!beat_oor(w)) begin
            for (int b = 0; b < 4; b++) if (s[b]) mdl[widx(w)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // which: 0=AW, 1=W, 2=AR. Returns after the handshake edge (+1).
    task automatic wait_hs(input int which, output bit ok);
        bit hs;
        int t = 0;
        do begin
            @(negedge ap_clk);
            hs = (which == 0) ? awready : (which == 1) ? wready : arready;
            @(posedge ap_clk);
            #1;
            t++;
        end while (!hs && t < TMO);
        ok = hs;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic id, input int gap);
        int len = wq_d.size() - 1;
        bit err = 1'b0;
        bit ok;
        for (int i = 0; i <= len; i++) if (beat_oor(beat_word(addr, i))) err = 1'b1;
        exp_b.push_back('{id, err ? 2'b10 : 2'b00});
        awaddr = addr; awid = id; awlen = 8'(len); awvalid = 1'b1;
        wait_hs(0, ok);
        awvalid = 1'b0;
        if (!ok) begin fail("aw_handshake"); return; end
        chk("wready_after_aw", wready, 1);
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, gap)) @(posedge ap_clk);
            #1;
            wvalid = 1'b1; wdata = wq_d[i]; wstrb = wq_s[i]; wlast = (i == len);
            wait_hs(1, ok);
            wvalid = 1'b0;
            if (!ok) begin fail("w_handshake"); return; end
            model_write(beat_word(addr, i), wq_d[i], wq_s[i]);
        end
        chk("bvalid_after_last_w", bvalid, 1);
    endtask

    task automatic do_read(input logic [63:0] addr, input int len, input logic id);
        bit ok;
        for (int i = 0; i <= len; i++) begin
            logic [63:0] w = beat_word(addr, i);
            exp_r.push_back('{beat_oor(w) ? 32'h0 : mdl[widx(w)], i == len, id,
                              beat_oor(w) ? 2'b10 : 2'b00});
        end
        araddr = addr; arid = id; arlen = 8'(len); arvalid = 1'b1;
        wait_hs(2, ok);
        arvalid = 1'b0;
        if (!ok) begin fail("ar_handshake"); return; end
        chk("rvalid_after_ar", rvalid, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0 || rvalid || bvalid) && t < 3000) begin
            @(posedge ap_clk);
            #1;
            t++;
        end
        if (t >= 3000) fail("drain");
    endtask

    task automatic fill_wq(input int n, input bit full_strb);
        wq_d.delete();
        wq_s.delete();
        for (int i = 0; i < n; i++) begin
            wq_d.push_back($urandom);
            wq_s.push_back(full_strb ? 4'hF : 4'($urandom_range(0, 15)));
        end
    endtask

    // Monitor: compares every R and B handshake against the scoreboard queues.
    logic [31:0] h_data;
    logic        h_last, h_id;
    logic [1:0]  h_resp;
    bit          held = 1'b0;
    always @(negedge ap_clk) begin
        r_exp_t er;
        b_exp_t eb;
        if (!ap_rst_n) begin
            held = 1'b0;
        end else begin
            if (rvalid) begin
                if (held) begin
                    chk("r_hold_data", rdata, h_data);
                    chk("r_hold_last", rlast, h_last);
                    chk("r_hold_id", rid, h_id);
                    chk("r_hold_resp", rresp, h_resp);
                end
                if (rready) begin
                    held = 1'b0;
                    if (exp_r.size() == 0) fail("r_unexpected");
                    else begin
                        er = exp_r.pop_front();
                        chk("r_data", rdata, er.data);
                        chk("r_last", rlast, er.last);
                        chk("r_id", rid, er.id);
                        chk("r_resp", rresp, er.resp);
                    end
                end else begin
                    held = 1'b1;
                    h_data = rdata; h_last = rlast; h_id = rid; h_resp = rresp;
                end
            end else begin
                held = 1'b0;
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) fail("b_unexpected");
                else begin
                    eb = exp_b.pop_front();
                    chk("b_id", bid, eb.id);
                    chk("b_resp", bresp, eb.resp);
                end
            end
        end
    end

    initial begin
        rready = 1'b0;
        bready = 1'b0;
        forever begin
            @(posedge ap_clk);
            #1;
            case (rr_mode)
                0:       rready = 1'b1;
                1:       rready = ~rready;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            bready = br_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [31:0] old, d;
        int          sel;
        bit          ok;

        ap_rst_n = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0;
        #2 ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("awready_after_rst", awready, 1);
        chk("arready_after_rst", arready, 1);

        for (int blk = 0; blk < 4; blk++) begin
            fill_wq(256, 1'b1);
            do_write(64'(blk * 1024), 1'b0, 0);
        end
        wait_idle();

        // Basic 4-beat write and read-back with IDs echoed.
        wq_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        wq_s = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(64'h40, 1'b1, 0);
        do_read(64'h40, 3, 1'b1);
        wait_idle();

        // Partial strobe over a zeroed word.
        wq_d = '{32'h0};          wq_s = '{4'hF};
        do_write(64'h80, 1'b0, 0);
        wq_d = '{32'hAABBCCDD};   wq_s = '{4'h5};
        do_write(64'h80, 1'b0, 0);
        do_read(64'h80, 0, 1'b0);
        wait_idle();

        // 8-beat read with RREADY toggling.
        rr_mode = 1;
        do_read(64'h100, 7, 1'b1);
        wait_idle();
        rr_mode = 0;

        // Read issued on the same edge as a write to the same word.
        old = mdl[200];
        d   = ~old;
        exp_b.push_back('{1'b0, 2'b00});
        awaddr = 64'h320; awlen = 8'd3; awid = 1'b0; awvalid = 1'b1;
        wait_hs(0, ok);
        awvalid = 1'b0;
        if (!ok) fail("ovl_aw");
        exp_r.push_back('{old, 1'b1, 1'b1, 2'b00});
        wvalid = 1'b1; wdata = d; wstrb = 4'hF; wlast = 1'b0;
        arvalid = 1'b1; araddr = 64'h320; arlen = 8'd0; arid = 1'b1;
        @(negedge ap_clk);
        chk("ovl_same_edge", {wready, arready}, 2'b11);
        @(posedge ap_clk);
        #1;
        model_write(64'd200, d, 4'hF);
        arvalid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            wdata = $urandom; wlast = (i == 3);
            @(posedge ap_clk);
            #1;
            model_write(64'(200 + i), wdata, 4'hF);
        end
        wvalid = 1'b0;
        wait_idle();
        do_read(64'h320, 3, 1'b0);
        wait_idle();

        // Address just past the array, and a read burst crossing the top.
        wq_d = '{32'hDEADBEEF};   wq_s = '{4'hF};
        do_write(64'h1000, 1'b1, 0);
        do_read(64'h0, 0, 1'b0);
        do_read(64'h1000, 0, 1'b1);
        do_read(64'hFF8, 3, 1'b0);
        wait_idle();

        // Randomized bursts with throttled RREADY/BREADY.
        rr_mode = 2;
        br_rand = 1'b1;
        for (int it = 0; it < 24; it++) begin
            a = 64'($urandom_range(0, DEPTH - 1)) * 4 + 64'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            if (sel == 0) a = a + 64'h1000;
            else if (sel == 1) a = a | (64'h5 << 40);
            fill_wq($urandom_range(1, 16), 1'b0);
            do_write(a, 1'($urandom_range(0, 1)), 2);
            do_read(a, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            wait_idle();
        end
        rr_mode = 0;
        br_rand = 1'b0;
        wait_idle();

        // Reset asserted in the middle of a read burst.
        rr_mode = 1;
        do_read(64'h200, 15, 1'b1);
        repeat (4) @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_arready", arready, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_rid", rid, 0);
        exp_r.delete();
        repeat (2) @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;
        rr_mode = 0;
        @(posedge ap_clk);
        #1;
        chk("arready_after_midrst", arready, 1);
        do_read(64'h200, 3, 1'b1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
